conv_out_collector: RTL and testbench
=====================================

Name: conv_out_collector

Overview:
Sink for the first conv layer's output stream. Accepts the 16-bit accumulator value qualified by the layer's valid strobe and requantises each value to 8 bits (ReLU, right shift, saturate). Stores the result in raster order in an on-chip output feature-map buffer. Exposes a registered read port and a frame-done flag, so the next layer (or the host) can fetch the map as a pixel stream.

Parameters:
OUT_W, 26, output feature-map width in pixels
OUT_H, 26, output feature-map height in pixels
DW, 16, input accumulator width (two's complement)
ADDR_W, 10, buffer address width; must satisfy 2**ADDR_W >= OUT_W*OUT_H

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; arms collection of a new frame
pxl_in  in  DW  conv accumulator value, signed
valid_in  in  1  pxl_in carries a valid output pixel this cycle
shift  in  4  requantisation right-shift amount (0..15)
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address, raster index row*OUT_W+col
rd_data  out  8  registered read data
busy  out  1  high while in COLLECT
done  out  1  high in DONE; full frame stored
overflow  out  1  sticky; a valid_in beat arrived in DONE
wr_count  out  ADDR_W  number of pixels written in the current frame

Behaviour:
- Reset (async) values: state=IDLE, wr_count=0, busy=0, done=0, overflow=0, rd_data=0. Buffer contents are not reset.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: valid_in ignored; start -> COLLECT, wr_count<=0, overflow<=0.
  - COLLECT: each cycle with valid_in=1 writes the requantised value to mem[wr_count], then wr_count<=wr_count+1. The write of index OUT_W*OUT_H-1 moves to DONE on the same edge, leaving wr_count=OUT_W*OUT_H. start in COLLECT restarts: wr_count<=0, stays in COLLECT, and any beat in that cycle is dropped.
  - DONE: valid_in beats are not written and set overflow<=1. start -> COLLECT, clears wr_count and overflow.
- Outputs: busy = (state==COLLECT); done = (state==DONE); both are registered state decodes.
- Requantisation, combinational before the write register:
  - if pxl_in[DW-1]=1, result=0 (ReLU);
  - else t = pxl_in >> shift (logical); result = (t>255) ? 255 : t[7:0].
- Write latency: a beat on cycle N is visible to a read issued on cycle N+1.
- Read port: synchronous, 1-cycle latency. rd_en on cycle N updates rd_data at the N+1 edge; rd_data holds when rd_en=0. Reads are legal in any state.
  - Same-cycle read and write to the same address returns the OLD content (read-first).
  - rd_addr >= OUT_W*OUT_H returns 0.
- Simultaneous start and the final write in COLLECT: start wins. wr_count<=0, state stays COLLECT, and the beat is dropped.
- Reset mid-frame: immediate return to IDLE. Partially written data remains but done=0.

Decomposition:
- Shared conv package holds DW, the default OUT_W/OUT_H per layer, the FSM state encoding (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2), and the requant saturation constant 255.
- One natural sub-module: fmap_ram. Single write port, single registered read port, read-first, depth 2**ADDR_W x 8, inferable as block RAM.
- Requantisation stays inline.

Test Plan:
- Reset then idle beats: assert reset, release, drive 10 valid_in beats without start -> wr_count=0, busy=0, done=0, overflow=0, rd_data=0.
- Full frame, shift=0: start, then 676 beats with pxl_in = index mod 200 -> done=1 exactly on the edge after beat 676, wr_count=676. Reading addr 0, 5, 675 returns 0, 5, 75 one cycle after rd_en.
- Requant corners, shift=2: pxl_in=16'hFFFF -> 0; 16'd1020 -> 255; 16'd1024 -> 255; 16'd100 -> 25; 16'h7FFF with shift=15 -> 0.
- Gapped valid: beats with valid_in toggled 1,0,0,1 between them -> only valid beats written. Addresses stay contiguous: 4 valid beats give wr_count=4.
- Overflow and restart: complete a frame, drive 3 extra beats -> overflow=1 and buffer unchanged. Pulse start -> overflow=0, busy=1, wr_count=0.
- Read/write collision and mid-frame reset: read addr 7 on the cycle beat 7 is written -> old value returned, new value on the next read. Assert reset after 300 beats -> state IDLE and done=0 immediately; addr 100 retains its written data.

Source files
------------

// File: rtl/conv_out_collector_pkg.sv
// Shared definitions for the first conv layer output path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_out_collector_pkg;

    // Accumulator width produced by the conv datapath.
    localparam int CONV_DW = 16;

    // Output feature-map geometry of the first conv layer.
    localparam int L1_OUT_W = 26;
    localparam int L1_OUT_H = 26;

    // Requantised pixels saturate to this value.
    localparam logic [7:0] SAT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } coll_state_e;

endpackage

// File: rtl/conv_out_collector_fmap_ram.sv
// Output feature-map buffer: one write port, one registered read port.
// Latency: write visible to a read issued on the following cycle; read data 1 cycle after re.
// Backpressure: none, accepts a write and a read every cycle; read-first on same-address collision.
//
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rd_q registered read data
// (holds its value while re is low).
module conv_out_collector_fmap_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_q
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // No reset on the array or the read register so the pair maps onto block RAM.
    // Both accesses in one process: the read samples the pre-write content.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rd_q <= mem[raddr];
        end
    end

endmodule

// File: rtl/conv_out_collector.sv
// Collects one conv output frame: ReLU + shift + saturate to 8 bits, stored in raster order.
// Latency: beat written on the edge it is presented; read data registered, 1 cycle after rd_en.
// Backpressure: none; beats outside a collection are dropped (flagged as overflow once done).
//
// Ports: clk, reset (async, active-high); start arms a frame; pxl_in/valid_in/shift input beat;
// rd_en/rd_addr/rd_data read port; busy/done/overflow status; wr_count pixels stored so far.
module conv_out_collector
    import conv_out_collector_pkg::*;
#(
    parameter int OUT_W  = L1_OUT_W,
    parameter int OUT_H  = L1_OUT_H,
    parameter int DW     = CONV_DW,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DW-1:0]     pxl_in,
    input  logic              valid_in,
    input  logic [3:0]        shift,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] wr_count
);

    localparam int N_PIX = OUT_W * OUT_H;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PIX - 1);

    coll_state_e state, state_nxt;

    logic          wr_en;
    logic          cnt_clr;
    logic          ovf_set;
    logic          ovf_clr;
    logic [DW-1:0] shifted;
    logic [7:0]    rq_dat;
    logic          rd_oob;
    logic          rd_oob_q;
    logic [7:0]    ram_q;

    // Requantisation: negative accumulators clip to zero, the rest are
    // shifted down and saturated to the 8-bit range.
    always_comb begin
        shifted = pxl_in >> shift;
        rq_dat  = 8'd0;
        if (!pxl_in[DW-1]) begin
            if (shifted > DW'(SAT_MAX)) begin
                rq_dat = SAT_MAX;
            end else begin
                rq_dat = shifted[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start has priority over any beat in the same cycle, including the
    // final pixel of a frame.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        cnt_clr   = 1'b0;
        ovf_set   = 1'b0;
        ovf_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_COLLECT;
                    cnt_clr   = 1'b1;
                    ovf_clr   = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (start) begin
                    cnt_clr = 1'b1;
                end else if (valid_in) begin
                    wr_en = 1'b1;
                    if (wr_count == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_COLLECT;
                    cnt_clr   = 1'b1;
                    ovf_clr   = 1'b1;
                end else if (valid_in) begin
                    ovf_set = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (cnt_clr) begin
                wr_count <= '0;
            end else if (wr_en) begin
                wr_count <= wr_count + 1'b1;
            end
            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

    assign busy = (state == ST_COLLECT);
    assign done = (state == ST_DONE);

    conv_out_collector_fmap_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_fmap_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_count),
        .wdata (rq_dat),
        .re    (rd_en),
        .raddr (rd_addr),
        .rd_q  (ram_q)
    );

    // Addresses past the frame read as zero. The flag is captured alongside
    // the RAM read and resets to 1, which also gives rd_data its zero reset
    // value without putting a reset on the RAM output register.
    assign rd_oob = (32'(rd_addr) >= N_PIX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_oob_q <= 1'b1;
        end else if (rd_en) begin
            rd_oob_q <= rd_oob;
        end
    end

    assign rd_data = rd_oob_q ? 8'd0 : ram_q;

endmodule

// File: tb/tb_conv_out_collector.sv
module tb_conv_out_collector;

    localparam int N = 26 * 26;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] pxl_in;
    logic        valid_in;
    logic [3:0]  shift;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [9:0]  wr_count;

    conv_out_collector dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pxl_in   (pxl_in),
        .valid_in (valid_in),
        .shift    (shift),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame phase (0 idle, 1 collecting, 2 complete),
    // pixels stored so far, overflow flag and the buffer contents.
    int m_phase;
    int m_cnt;
    int m_ovf;
    int m_mem   [0:1023];
    bit m_known [0:1023];
    int e_rd;
    bit e_rd_ok;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rq(input logic [15:0] px, input logic [3:0] sh);
        int v;
        v = int'($signed(px));
        if (v < 0) return 0;
        v = v / (1 << sh);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_ovf   = 0;
        e_rd    = 0;
        e_rd_ok = 1'b1;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".busy"},     busy,     (m_phase == 1));
        chk({ctx, ".done"},     done,     (m_phase == 2));
        chk({ctx, ".overflow"}, overflow, m_ovf);
        chk({ctx, ".wr_count"}, wr_count, m_cnt);
        if (e_rd_ok) chk({ctx, ".rd_data"}, rd_data, e_rd);
    endtask

    // One clock cycle: drive inputs, take the edge, advance the model, compare.
    task automatic step(input logic st, input logic vl, input logic [15:0] px,
                        input logic [3:0] sh, input logic re, input logic [9:0] ra,
                        input string ctx);
        start = st; valid_in = vl; pxl_in = px; shift = sh; rd_en = re; rd_addr = ra;
        @(posedge clk);
        #1;
        if (re) begin
            if (int'(ra) >= N) begin
                e_rd = 0; e_rd_ok = 1'b1;
            end else begin
                e_rd = m_mem[ra]; e_rd_ok = m_known[ra];
            end
        end
        case (m_phase)
            0: if (st) begin m_phase = 1; m_cnt = 0; m_ovf = 0; end
            1: begin
                if (st) begin
                    m_cnt = 0;
                end else if (vl) begin
                    m_mem[m_cnt]   = rq(px, sh);
                    m_known[m_cnt] = 1'b1;
                    m_cnt++;
                    if (m_cnt == N) m_phase = 2;
                end
            end
            default: begin
                if (st) begin m_phase = 1; m_cnt = 0; m_ovf = 0; end
                else if (vl) m_ovf = 1;
            end
        endcase
        check_outputs(ctx);
    endtask

    task automatic beat(input logic [15:0] px, input logic [3:0] sh, input string ctx);
        step(1'b0, 1'b1, px, sh, 1'b0, 10'd0, ctx);
    endtask

    task automatic rd(input int a, input string ctx);
        step(1'b0, 1'b0, 16'd0, 4'd0, 1'b1, 10'(a), ctx);
    endtask

    task automatic kick(input string ctx);
        step(1'b1, 1'b0, 16'd0, 4'd0, 1'b0, 10'd0, ctx);
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset(input string ctx);
        start = 1'b0; valid_in = 1'b0; rd_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs({ctx, ".imm"});
        @(posedge clk);
        #1;
        check_outputs({ctx, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] px;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) begin m_mem[i] = 0; m_known[i] = 1'b0; end
        reset = 1'b1; start = 1'b0; valid_in = 1'b0; pxl_in = '0; shift = '0;
        rd_en = 1'b0; rd_addr = '0;
        model_reset();
        #12;
        check_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Beats without start are ignored.
        for (int i = 0; i < 10; i++) beat(16'(i + 3), 4'd0, "idle_beat");

        // Full frame at shift 0.
        kick("start_full");
        for (int i = 0; i < N; i++) beat(16'(i % 200), 4'd0, "full");
        chk("full.done_final", done, 1);
        chk("full.cnt_final", wr_count, 676);
        rd(0,   "rd0");   chk("rd0.val",   rd_data, 0);
        rd(5,   "rd5");   chk("rd5.val",   rd_data, 5);
        rd(675, "rd675"); chk("rd675.val", rd_data, 75);
        rd(700, "rd_oob"); chk("rd_oob.val", rd_data, 0);
        step(1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 10'd5, "rd_hold");

        // Overflow beats leave the buffer untouched; start clears the flag.
        for (int i = 0; i < 3; i++) beat(16'(i + 150), 4'd0, "ovf_beat");
        rd(0, "ovf_rd0"); rd(1, "ovf_rd1"); rd(2, "ovf_rd2");
        kick("restart");

        // Requantisation corners.
        beat(16'hFFFF, 4'd2,  "rq_neg");
        beat(16'd1020, 4'd2,  "rq_1020");
        beat(16'd1024, 4'd2,  "rq_1024");
        beat(16'd100,  4'd2,  "rq_100");
        beat(16'h7FFF, 4'd15, "rq_7fff");
        rd(0, "rq_rd0"); chk("rq0", rd_data, 0);
        rd(1, "rq_rd1"); chk("rq1", rd_data, 255);
        rd(2, "rq_rd2"); chk("rq2", rd_data, 255);
        rd(3, "rq_rd3"); chk("rq3", rd_data, 25);
        rd(4, "rq_rd4"); chk("rq4", rd_data, 0);

        // Gapped valid: only strobed beats advance the write pointer.
        kick("gap_start");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i % 3 == 0), 16'(40 + i), 4'd0, 1'b0, 10'd0, "gap");
        end
        chk("gap.cnt", wr_count, 4);
        for (int i = 0; i < 4; i++) rd(i, "gap_rd");

        // Read/write collision at index 7, then a mid-frame reset.
        kick("col_start");
        for (int i = 0; i < 7; i++) beat(16'(200 + i), 4'd0, "col_pre");
        step(1'b0, 1'b1, 16'd99, 4'd0, 1'b1, 10'd7, "col_same");
        chk("col.old", rd_data, 7);
        rd(7, "col_new");
        chk("col.new", rd_data, 99);
        for (int i = 8; i < 300; i++) beat(16'($urandom), 4'($urandom), "pre_rst");
        async_reset("midrst");
        rd(100, "rst_rd100");

        // Start colliding with the final write of a frame.
        kick("fin_start");
        for (int i = 0; i < N - 1; i++) beat(16'($urandom), 4'($urandom), "fin");
        step(1'b1, 1'b1, 16'd77, 4'd0, 1'b0, 10'd0, "fin_collide");
        chk("fin.cnt", wr_count, 0);
        chk("fin.busy", busy, 1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            px = 16'($urandom);
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 9) < 7), px,
                 4'($urandom_range(0, 15)), 1'($urandom), 10'($urandom_range(0, 1023)),
                 "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
